// File: rtl/piano_pkg.sv
// Shared piano constants: note/tempo/address widths, marker values and the
// recorder FSM state encoding.
package piano_pkg;

  localparam int LARGURA_ADDR  = 5;
  localparam int LARGURA_NOTA  = 4;
  localparam int LARGURA_TEMPO = 4;

  localparam logic [LARGURA_NOTA-1:0]  NOTA_SILENCIO = 4'd0;
  localparam logic [LARGURA_TEMPO-1:0] TEMPO_FIM     = 4'd0;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ESPERA   = 3'd1,
    NOTA     = 3'd2,
    REST     = 3'd3,
    ESCREVE  = 3'd4,
    FINALIZA = 3'd5,
    PRONTO   = 3'd6
  } estado_grav_t;

endpackage

// File: rtl/gravador_musica_contador_duracao.sv
// Saturating beat counter: loads 1 when an event opens, then counts metronome
// ticks up to the all-ones value.
module contador_duracao
  import piano_pkg::*;
#(
  parameter int W = LARGURA_TEMPO
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic         conta,
  output logic [W-1:0] valor
);

  localparam logic [W-1:0] UM     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAXIMO = {W{1'b1}};

  // Load has priority so a tick in the opening cycle belongs to the old event.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valor <= '0;
    end else if (carrega) begin
      valor <= UM;
    end else if (conta && (valor != MAXIMO)) begin
      valor <= valor + UM;
    end
  end

endmodule

// File: rtl/gravador_musica.sv
// Melody recorder: turns key presses/releases into {nota, tempo} entries of the
// shared song RAM and terminates the song with a {0,0} end marker.
module gravador_musica
  import piano_pkg::*;
#(
  parameter int ADDR_W  = LARGURA_ADDR,
  parameter int NOTA_W  = LARGURA_NOTA,
  parameter int TEMPO_W = LARGURA_TEMPO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicia,
  input  logic               para,
  input  logic [NOTA_W-1:0]  botoes_encoded,
  input  logic               metro,
  output logic               we,
  output logic [ADDR_W-1:0]  addr,
  output logic [NOTA_W-1:0]  data_nota,
  output logic [TEMPO_W-1:0] data_tempo,
  output logic               gravando,
  output logic               pronto,
  output logic [ADDR_W:0]    num_eventos
);

  localparam logic [ADDR_W-1:0]  ADDR_UM      = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]  ADDR_ULT_EVT = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W:0]    NUM_UM       = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [TEMPO_W-1:0] TEMPO_UM     = {{(TEMPO_W-1){1'b0}}, 1'b1};
  localparam logic [TEMPO_W-1:0] TEMPO_MAX    = {TEMPO_W{1'b1}};

  estado_grav_t       estado_r;
  logic [NOTA_W-1:0]  nota_r;
  logic               para_r;
  logic               evento_nota_r;
  logic [TEMPO_W-1:0] dur_s;
  logic [TEMPO_W-1:0] tempo_fecho_s;
  logic               carrega_s;
  logic               tecla_ativa_s;
  logic               mudou_s;

  assign tecla_ativa_s = (botoes_encoded != NOTA_SILENCIO);
  assign mudou_s       = (botoes_encoded != nota_r);
  // A tick coinciding with the close still belongs to the closing event.
  assign tempo_fecho_s = (metro && (dur_s != TEMPO_MAX)) ? (dur_s + TEMPO_UM) : dur_s;

  contador_duracao #(.W(TEMPO_W)) u_dur (
    .clock   (clock),
    .reset   (reset),
    .carrega (carrega_s),
    .conta   (metro),
    .valor   (dur_s)
  );

  // Key register: all change detection compares the live input against it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nota_r <= NOTA_SILENCIO;
    end else begin
      nota_r <= botoes_encoded;
    end
  end

  // Open a new event whenever one closes (or the first key arrives).
  always_comb begin
    carrega_s = 1'b0;
    case (estado_r)
      ESPERA:  carrega_s = tecla_ativa_s;
      NOTA:    carrega_s = mudou_s && !para;
      REST:    carrega_s = tecla_ativa_s && !para;
      default: carrega_s = 1'b0;
    endcase
  end

  // Recorder FSM with registered RAM write port and status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r      <= OCIOSO;
      we            <= 1'b0;
      addr          <= '0;
      data_nota     <= NOTA_SILENCIO;
      data_tempo    <= TEMPO_FIM;
      gravando      <= 1'b0;
      pronto        <= 1'b0;
      num_eventos   <= '0;
      para_r        <= 1'b0;
      evento_nota_r <= 1'b0;
    end else begin
      we <= 1'b0;
      case (estado_r)
        OCIOSO, PRONTO: begin
          if (inicia) begin
            estado_r    <= ESPERA;
            addr        <= '0;
            num_eventos <= '0;
            pronto      <= 1'b0;
            gravando    <= 1'b1;
            para_r      <= 1'b0;
          end
        end
        ESPERA: begin
          if (tecla_ativa_s) begin
            estado_r <= NOTA;
          end else if (para) begin
            estado_r   <= FINALIZA;
            we         <= 1'b1;
            data_nota  <= NOTA_SILENCIO;
            data_tempo <= TEMPO_FIM;
            gravando   <= 1'b0;
          end
        end
        NOTA: begin
          if (mudou_s || para) begin
            estado_r      <= ESCREVE;
            we            <= 1'b1;
            data_nota     <= nota_r;
            data_tempo    <= tempo_fecho_s;
            para_r        <= para;
            evento_nota_r <= tecla_ativa_s;
            gravando      <= 1'b0;
          end
        end
        REST: begin
          // A rest closed by stop is trailing silence and is dropped.
          if (para) begin
            estado_r   <= FINALIZA;
            we         <= 1'b1;
            data_nota  <= NOTA_SILENCIO;
            data_tempo <= TEMPO_FIM;
            gravando   <= 1'b0;
          end else if (tecla_ativa_s) begin
            estado_r      <= ESCREVE;
            we            <= 1'b1;
            data_nota     <= NOTA_SILENCIO;
            data_tempo    <= tempo_fecho_s;
            evento_nota_r <= 1'b1;
            gravando      <= 1'b0;
          end
        end
        ESCREVE: begin
          addr        <= addr + ADDR_UM;
          num_eventos <= num_eventos + NUM_UM;
          if (para_r || para || (addr == ADDR_ULT_EVT)) begin
            estado_r   <= FINALIZA;
            we         <= 1'b1;
            data_nota  <= NOTA_SILENCIO;
            data_tempo <= TEMPO_FIM;
          end else begin
            estado_r <= evento_nota_r ? NOTA : REST;
            gravando <= 1'b1;
          end
        end
        FINALIZA: begin
          estado_r <= PRONTO;
          pronto   <= 1'b1;
        end
        default: begin
          estado_r <= OCIOSO;
          gravando <= 1'b0;
          pronto   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gravador_musica.sv
// Bench for gravador_musica: directed and random melodies checked against an
// event-level model of what the song RAM should contain.
module tb_gravador_musica;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       inicia = 1'b0;
  logic       para = 1'b0;
  logic       metro = 1'b0;
  logic [3:0] botoes_encoded = 4'd0;
  logic       we;
  logic [4:0] addr;
  logic [3:0] data_nota;
  logic [3:0] data_tempo;
  logic       gravando;
  logic       pronto;
  logic [5:0] num_eventos;

  int checks = 0;
  int failures = 0;

  logic [12:0] obs_q[$];
  int          stim_key[$];
  bit          stim_metro[$];
  bit          stim_para[$];
  logic [3:0]  exp_nota[$];
  logic [3:0]  exp_tempo[$];

  gravador_musica dut (
    .clock          (clock),
    .reset          (reset),
    .inicia         (inicia),
    .para           (para),
    .botoes_encoded (botoes_encoded),
    .metro          (metro),
    .we             (we),
    .addr           (addr),
    .data_nota      (data_nota),
    .data_tempo     (data_tempo),
    .gravando       (gravando),
    .pronto         (pronto),
    .num_eventos    (num_eventos)
  );

  always #5 clock = ~clock;

  // Capture every RAM write on the falling edge.
  always @(negedge clock) begin
    if (we === 1'b1) obs_q.push_back({addr, data_nota, data_tempo});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int k, input bit m, input bit p);
    botoes_encoded = 4'(k);
    metro = m;
    para = p;
    @(posedge clock);
    #1;
  endtask

  // Key held for 2*nticks+2 cycles with nticks ticks strictly inside it.
  task automatic add_seg(input int key, input int nticks);
    for (int i = 0; i < 2 * nticks + 2; i++) begin
      stim_key.push_back(key);
      stim_metro.push_back((i % 2 == 1) && (i < 2 * nticks));
      stim_para.push_back(1'b0);
    end
  endtask

  task automatic add_para();
    int last;
    last = (stim_key.size() > 0) ? stim_key[stim_key.size() - 1] : 0;
    stim_key.push_back(last);
    stim_metro.push_back(1'b0);
    stim_para.push_back(1'b1);
  endtask

  task automatic push_exp(input int nota, input int beats);
    exp_nota.push_back(4'(nota));
    exp_tempo.push_back(4'((beats > 15) ? 15 : beats));
  endtask

  // Event model: each constant-key span is one entry; its length is 1 plus
  // the ticks from the cycle after it opens up to and including its close.
  task automatic model();
    int  prev;
    int  cur;
    int  ticks;
    bit  open;
    bit  done;
    exp_nota.delete();
    exp_tempo.delete();
    prev = 0; cur = 0; ticks = 0; open = 1'b0; done = 1'b0;
    for (int k = 0; k < stim_key.size(); k++) begin
      if (!done) begin
        if (stim_para[k]) begin
          if (open && cur != 0) push_exp(cur, 1 + ticks + int'(stim_metro[k]));
          done = 1'b1;
        end else if (stim_key[k] != prev) begin
          if (open) push_exp(cur, 1 + ticks + int'(stim_metro[k]));
          open = 1'b1;
          cur = stim_key[k];
          ticks = 0;
        end else if (open) begin
          ticks += int'(stim_metro[k]);
        end
        prev = stim_key[k];
        if (exp_nota.size() == 31) done = 1'b1;
      end
    end
  endtask

  task automatic run_and_check(input string name);
    int n;
    model();
    obs_q.delete();
    inicia = 1'b1;
    step(0, 1'b0, 1'b0);
    inicia = 1'b0;
    for (int k = 0; k < stim_key.size(); k++) step(stim_key[k], stim_metro[k], stim_para[k]);
    for (int k = 0; k < 6; k++) step(0, 1'b0, 1'b0);
    n = exp_nota.size();
    check({name, "_writes"}, obs_q.size(), n + 1);
    for (int i = 0; i < n && i < obs_q.size(); i++)
      check($sformatf("%s_e%0d", name, i), obs_q[i], {5'(i), exp_nota[i], exp_tempo[i]});
    if (obs_q.size() > n) check({name, "_marker"}, obs_q[n], {5'(n), 4'd0, 4'd0});
    check({name, "_num"}, num_eventos, n);
    check({name, "_pronto"}, pronto, 1);
    check({name, "_gravando"}, gravando, 0);
    check({name, "_we_idle"}, we, 0);
    stim_key.delete();
    stim_metro.delete();
    stim_para.delete();
  endtask

  initial begin
    int prev;
    int key;
    int len;

    #12;
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_data", {data_nota, data_tempo}, 0);
    check("rst_status", {gravando, pronto}, 0);
    check("rst_num", num_eventos, 0);
    reset = 1'b1;
    step(0, 1'b0, 1'b0);

    // para while idle must be ignored
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0);
    check("idle_para_we", obs_q.size(), 0);
    check("idle_para_pronto", pronto, 0);

    add_seg(5, 3); add_seg(0, 2); add_seg(7, 1); add_para();
    run_and_check("basic");
    check("basic_c0", obs_q[0], {5'd0, 4'd5, 4'd4});
    check("basic_c1", obs_q[1], {5'd1, 4'd0, 4'd3});
    check("basic_c2", obs_q[2], {5'd2, 4'd7, 4'd2});

    add_seg(3, 2); add_seg(9, 3); add_para();
    run_and_check("direct");
    check("direct_c1", obs_q[1], {5'd1, 4'd9, 4'd4});

    add_seg(2, 20); add_seg(0, 1); add_seg(4, 0); add_seg(0, 1); add_para();
    run_and_check("satmin");
    check("satmin_sat", obs_q[0], {5'd0, 4'd2, 4'd15});
    check("satmin_min", obs_q[2], {5'd2, 4'd4, 4'd1});

    add_seg(0, 3); add_seg(6, 1); add_seg(0, 4); add_para();
    run_and_check("trail");
    check("trail_c0", obs_q[0], {5'd0, 4'd6, 4'd2});

    for (int i = 0; i < 34; i++) add_seg((i % 2 == 0) ? 1 + (i % 15) : 0, int'($urandom_range(0, 2)));
    run_and_check("full");
    check("full_count", obs_q.size(), 32);
    check("full_num", num_eventos, 31);

    // random melodies, ticks may land on any cycle including event edges
    for (int r = 0; r < 5; r++) begin
      add_seg(0, int'($urandom_range(0, 2)));
      prev = 0;
      for (int s = 0; s < int'($urandom_range(3, 12)); s++) begin
        key = int'($urandom_range(0, 15));
        if (key == prev) key = (prev + 1) % 16;
        if (s == 0 && key == 0) key = 1;
        len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(2, 8));
        for (int c = 0; c < len; c++) begin
          stim_key.push_back(key);
          stim_metro.push_back($urandom_range(0, 2) == 0);
          stim_para.push_back(1'b0);
        end
        prev = key;
      end
      stim_key.push_back(prev);
      stim_metro.push_back($urandom_range(0, 1) == 1);
      stim_para.push_back(1'b1);
      run_and_check($sformatf("rand%0d", r));
    end

    // async reset while a write is on the bus
    inicia = 1'b1;
    step(0, 1'b0, 1'b0);
    inicia = 1'b0;
    step(5, 1'b0, 1'b0);
    step(5, 1'b1, 1'b0);
    step(5, 1'b0, 1'b0);
    step(8, 1'b0, 1'b0);
    check("arst_pre_we", we, 1);
    check("arst_pre_grav", gravando, 0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_we", we, 0);
    check("arst_addr", addr, 0);
    check("arst_grav", gravando, 0);
    check("arst_num", num_eventos, 0);
    reset = 1'b1;
    step(0, 1'b0, 1'b0);
    add_seg(4, 1); add_para();
    run_and_check("after_rst");
    check("after_rst_c0", obs_q[0], {5'd0, 4'd4, 4'd2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
